calc_multi_engine: RTL and testbench

- Parametrised successor to the four-port calc1 calculator.
- Serves NUM_PORTS independent request ports, each with its own DATA_W-bit operands, through one shared registered ALU.
- Arbitration between ports is round-robin, replacing the old fixed port order.
- Sits between request sources and the response collectors; each port has its own two-cycle command/operand protocol and its own one-cycle response.

---
 rtl/calc_pkg.sv | 27 ++
 rtl/calc_multi_engine_if.sv | 28 ++
 rtl/calc_rr_arbiter.sv | 44 ++++
 rtl/calc_multi_engine.sv | 162 ++++++++++++++++
 tb/tb_calc_multi_engine.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared command/response encodings and port FSM states for the
// multi-port calculator engine.
package calc_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_OVF  = 2'd2;
    localparam logic [1:0] RESP_INV  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OP2,
        ST_PEND
    } port_state_t;

    function automatic logic is_known_cmd(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
               (cmd == CMD_SHL) || (cmd == CMD_SHR);
    endfunction

endpackage

// File: rtl/calc_multi_engine_if.sv
// Request/response bundle of the calculator engine. Vectors are MSB-first:
// port p owns the slice starting at p*width.
interface calc_multi_engine_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32
);
    logic [0:NUM_PORTS*4-1]      req_cmd_in;
    logic [0:NUM_PORTS*DATA_W-1] req_data_in;
    logic [0:NUM_PORTS*2-1]      out_resp;
    logic [0:NUM_PORTS*DATA_W-1] out_data;
    logic [0:NUM_PORTS-1]        busy;

    modport master (
        output req_cmd_in,
        output req_data_in,
        input  out_resp,
        input  out_data,
        input  busy
    );

    modport slave (
        input  req_cmd_in,
        input  req_data_in,
        output out_resp,
        output out_data,
        output busy
    );
endinterface

// File: rtl/calc_rr_arbiter.sv
// Round-robin arbiter: at most one grant per cycle, the search starts at the
// priority pointer, which moves to granted+1 after every grant.
module calc_rr_arbiter #(
    parameter  int NUM_PORTS = 4,
    localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 c_clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx_v;
    logic             found;

    // NOTE: every variable gets a default before the search loop so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx_v     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx_v = IDX_W'((int'(ptr) + i) % NUM_PORTS);
            if (advance && !found && req[idx_v]) begin
                grant[idx_v] = 1'b1;
                grant_idx    = idx_v;
                found        = 1'b1;
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/calc_multi_engine.sv
// NUM_PORTS independent two-cycle request ports sharing one registered ALU
// through a round-robin arbiter; each result is a one-cycle response pulse.
module calc_multi_engine
    import calc_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int SHIFT_W   = $clog2(DATA_W)
) (
    input  logic         c_clk,
    input  logic         reset,
    calc_multi_engine_if.slave bus
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [3:0]        cmd_q [NUM_PORTS];
    logic [DATA_W-1:0] op1_q [NUM_PORTS];
    logic [DATA_W-1:0] op2_q [NUM_PORTS];

    logic [NUM_PORTS-1:0] pend;
    logic [NUM_PORTS-1:0] grant;
    logic [IDX_W-1:0]     grant_idx;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        port_state_t       state;
        logic              busy_r;
        logic [3:0]        cmd_r;
        logic [DATA_W-1:0] op1_r;
        logic [DATA_W-1:0] op2_r;
        logic [3:0]        cmd_in;
        logic [DATA_W-1:0] data_in;

        assign cmd_in  = bus.req_cmd_in[p*4 +: 4];
        assign data_in = bus.req_data_in[p*DATA_W +: DATA_W];

        // NOTE: sequential state uses non-blocking assignments so every port
        // and the arbiter see the same pre-edge values.
        always_ff @(posedge c_clk) begin
            if (reset) begin
                state  <= ST_IDLE;
                busy_r <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cmd_in != CMD_NOP) begin
                            state  <= ST_OP2;
                            busy_r <= 1'b1;
                        end
                    end
                    ST_OP2: state <= ST_PEND;
                    ST_PEND: begin
                        if (grant[p]) begin
                            state  <= ST_IDLE;
                            busy_r <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end

        // NOTE: operand registers carry no reset; the FSM state decides
        // whether their contents are ever used.
        always_ff @(posedge c_clk) begin
            if (state == ST_IDLE && cmd_in != CMD_NOP) begin
                cmd_r <= cmd_in;
                op1_r <= data_in;
            end
            if (state == ST_OP2) begin
                op2_r <= data_in;
            end
        end

        assign cmd_q[p]    = cmd_r;
        assign op1_q[p]    = op1_r;
        assign op2_q[p]    = op2_r;
        assign pend[p]     = (state == ST_PEND);
        assign bus.busy[p] = busy_r;
    end

    calc_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .c_clk     (c_clk),
        .reset     (reset),
        .req       (pend),
        .advance   (!reset),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    logic [3:0]         g_cmd;
    logic [DATA_W-1:0]  g_op1;
    logic [DATA_W-1:0]  g_op2;
    logic [DATA_W:0]    sum;
    logic [SHIFT_W-1:0] amt;
    logic [1:0]         alu_resp;
    logic [DATA_W-1:0]  alu_data;

    assign g_cmd = cmd_q[grant_idx];
    assign g_op1 = op1_q[grant_idx];
    assign g_op2 = op2_q[grant_idx];
    assign sum   = {1'b0, g_op1} + {1'b0, g_op2};
    assign amt   = g_op2[SHIFT_W-1:0];

    always_comb begin
        alu_resp = RESP_INV;
        alu_data = '0;
        if (is_known_cmd(g_cmd)) begin
            case (g_cmd)
                CMD_ADD: begin
                    alu_resp = sum[DATA_W] ? RESP_OVF : RESP_OK;
                    alu_data = sum[DATA_W] ? '0 : sum[DATA_W-1:0];
                end
                CMD_SUB: begin
                    alu_resp = (g_op2 > g_op1) ? RESP_OVF : RESP_OK;
                    alu_data = (g_op2 > g_op1) ? '0 : g_op1 - g_op2;
                end
                CMD_SHL: begin
                    alu_resp = RESP_OK;
                    alu_data = g_op1 << amt;
                end
                CMD_SHR: begin
                    alu_resp = RESP_OK;
                    alu_data = g_op1 >> amt;
                end
                default: begin
                    alu_resp = RESP_INV;
                    alu_data = '0;
                end
            endcase
        end
    end

    logic [0:NUM_PORTS*2-1]      resp_r;
    logic [0:NUM_PORTS*DATA_W-1] data_r;

    // Every slice falls back to zero each cycle, so a response is a single pulse.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            resp_r <= '0;
            data_r <= '0;
        end else begin
            resp_r <= '0;
            data_r <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant[p]) begin
                    resp_r[p*2 +: 2]           <= alu_resp;
                    data_r[p*DATA_W +: DATA_W] <= alu_data;
                end
            end
        end
    end

    assign bus.out_resp = resp_r;
    assign bus.out_data = data_r;

endmodule

// File: tb/tb_calc_multi_engine.sv
// Scoreboard bench for calc_multi_engine: stimulus pushes expected responses
// from an arithmetic reference model, a negedge monitor pops and compares.
module tb_calc_multi_engine;
    import calc_pkg::*;

    localparam int NP = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct packed {
        int port;
        int cyc;
    } log_t;

    logic c_clk = 1'b0;
    logic reset;
    always #5 c_clk = ~c_clk;

    calc_multi_engine_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();
    calc_multi_engine #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    calc_multi_engine_if #(.NUM_PORTS(2), .DATA_W(16)) bus16 ();
    calc_multi_engine #(.NUM_PORTS(2), .DATA_W(16)) dut16 (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus16)
    );

    exp_t          exp_q [NP][$];
    log_t          rsp_log[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    bit            mon_en = 1'b0;
    int            resp_cnt [NP];
    int            last_cyc [NP];
    logic [1:0]    last_resp [NP];
    logic [DW-1:0] last_data [NP];
    int            issue_cyc;

    logic [3:0]    r_cmd [NP];
    logic [DW-1:0] r_op1 [NP];
    logic [DW-1:0] r_op2 [NP];

    always @(posedge c_clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: plain unsigned arithmetic on 64-bit integers.
    function automatic exp_t model(input logic [3:0] cmd, input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint unsigned ua  = 64'(a);
        longint unsigned ub  = 64'(b);
        longint unsigned lim = 64'd1 << DW;
        int              sh  = int'(ub % DW);
        exp_t            e;
        e.resp = RESP_INV;
        e.data = '0;
        case (cmd)
            4'd1: if (ua + ub >= lim) e.resp = RESP_OVF;
                  else begin e.resp = RESP_OK; e.data = DW'(ua + ub); end
            4'd2: if (ub > ua) e.resp = RESP_OVF;
                  else begin e.resp = RESP_OK; e.data = DW'(ua - ub); end
            4'd5: begin e.resp = RESP_OK; e.data = DW'((ua * (64'd1 << sh)) % lim); end
            4'd6: begin e.resp = RESP_OK; e.data = DW'(ua / (64'd1 << sh)); end
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge c_clk) begin
        if (mon_en) begin
            int   nz;
            logic idle_bad;
            nz       = 0;
            idle_bad = 1'b0;
            for (int p = 0; p < NP; p++) begin
                logic [1:0]    r;
                logic [DW-1:0] d;
                exp_t          e;
                r = bus.out_resp[p*2 +: 2];
                d = bus.out_data[p*DW +: DW];
                if (r != 2'd0) begin
                    nz++;
                    resp_cnt[p]++;
                    last_cyc[p]  = cyc;
                    last_resp[p] = r;
                    last_data[p] = d;
                    rsp_log.push_back('{p, cyc});
                    if (exp_q[p].size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_resp_p%0d: got resp %0d data 0x%0h, expected none", p, r, d);
                    end else begin
                        e = exp_q[p].pop_front();
                        check($sformatf("resp_p%0d", p), 64'(r), 64'(e.resp));
                        check($sformatf("data_p%0d", p), 64'(d), 64'(e.data));
                    end
                end else if (d != '0) begin
                    idle_bad = 1'b1;
                end
            end
            check("idle_slices_zero", 64'(idle_bad), 64'd0);
            check("single_grant", 64'(nz <= 1), 64'd1);
        end
    end

    function automatic bit any_pending();
        for (int p = 0; p < NP; p++) if (exp_q[p].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Called at #1 after a rising edge; returns with the issued ports in PEND
    // (or, with drop set, just after the grant edge of an uncontested port).
    task automatic issue_round(input logic [NP-1:0] mask, input logic [NP-1:0] exp_mask, input bit drop);
        issue_cyc = cyc;
        for (int p = 0; p < NP; p++) begin
            if (mask[p] && r_cmd[p] != 4'd0) begin
                bus.req_cmd_in[p*4 +: 4]    = r_cmd[p];
                bus.req_data_in[p*DW +: DW] = r_op1[p];
                if (exp_mask[p]) exp_q[p].push_back(model(r_cmd[p], r_op1[p], r_op2[p]));
            end
        end
        @(posedge c_clk); #1;
        for (int p = 0; p < NP; p++) begin
            if (mask[p]) begin
                bus.req_data_in[p*DW +: DW] = r_op2[p];
                bus.req_cmd_in[p*4 +: 4]    = drop ? 4'd1 : 4'd0;
            end
        end
        @(posedge c_clk); #1;
        for (int p = 0; p < NP; p++) begin
            if (mask[p]) begin
                bus.req_cmd_in[p*4 +: 4]    = drop ? 4'd2 : 4'd0;
                bus.req_data_in[p*DW +: DW] = $urandom;
            end
        end
        if (drop) begin
            @(posedge c_clk); #1;
            bus.req_cmd_in = '0;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (any_pending() && n < 60) begin
            @(posedge c_clk); #1;
            n++;
        end
        check({name, "_drain_in_time"}, 64'(n < 60), 64'd1);
        for (int p = 0; p < NP; p++) exp_q[p].delete();
        @(posedge c_clk); #1;
    endtask

    task automatic run1(input string name, input int port, input logic [3:0] cmd,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [1:0] want_resp, input logic [DW-1:0] want_data);
        r_cmd[port] = cmd;
        r_op1[port] = a;
        r_op2[port] = b;
        issue_round(NP'(1) << port, NP'(1) << port, 1'b0);
        drain(name);
        check({name, "_resp"}, 64'(last_resp[port]), 64'(want_resp));
        check({name, "_data"}, 64'(last_data[port]), 64'(want_data));
    endtask

    task automatic check_order(input string name, input int first);
        check({name, "_count"}, 64'(rsp_log.size()), 64'(NP));
        for (int i = 0; i < NP && i < rsp_log.size(); i++) begin
            check($sformatf("%s_port%0d", name, i), 64'(rsp_log[i].port), 64'((first + i) % NP));
            check($sformatf("%s_cyc%0d", name, i), 64'(rsp_log[i].cyc - rsp_log[0].cyc), 64'(i));
        end
    endtask

    function automatic logic [DW-1:0] rand_val();
        case ($urandom_range(0, 3))
            0: return 32'hFFFF_FFFF - DW'($urandom_range(0, 3));
            1: return DW'($urandom_range(0, 40));
            2: return DW'($urandom);
            default: return DW'(1) << $urandom_range(0, DW - 1);
        endcase
    endfunction

    initial begin
        reset             = 1'b1;
        bus.req_cmd_in    = '0;
        bus.req_data_in   = '0;
        bus16.req_cmd_in  = '0;
        bus16.req_data_in = '0;
        for (int p = 0; p < NP; p++) begin
            resp_cnt[p] = 0; last_cyc[p] = 0; last_resp[p] = '0; last_data[p] = '0;
            r_cmd[p] = '0; r_op1[p] = '0; r_op2[p] = '0;
        end
        repeat (2) @(posedge c_clk);
        #1;
        reset = 1'b0;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_resp", 64'(bus.out_resp), 64'd0);
        check("reset_data_zero", 64'(bus.out_data == '0), 64'd1);
        mon_en = 1'b1;

        run1("add_basic", 0, CMD_ADD, 32'h1, 32'h1FFF_FFFF, RESP_OK, 32'h2000_0000);
        check("add_latency", 64'(last_cyc[0] - issue_cyc), 64'd3);
        run1("add_ovf", 0, CMD_ADD, 32'hFFFF_FFFF, 32'h1, RESP_OVF, 32'h0);
        run1("sub_unf", 0, CMD_SUB, 32'h1, 32'hF, RESP_OVF, 32'h0);
        run1("sub_ok", 0, CMD_SUB, 32'hF, 32'h1, RESP_OK, 32'hE);
        run1("shl", 0, CMD_SHL, 32'h1, 32'h24, RESP_OK, 32'h10);
        run1("shr", 0, CMD_SHR, 32'h8000_0000, 32'd31, RESP_OK, 32'h1);
        run1("inv3", 0, 4'd3, 32'h5, 32'h6, RESP_INV, 32'h0);
        run1("inv4", 0, 4'd4, 32'h5, 32'h6, RESP_INV, 32'h0);

        begin
            int c0;
            c0       = resp_cnt[0];
            r_cmd[0] = CMD_ADD; r_op1[0] = 32'd10; r_op2[0] = 32'd20;
            issue_round(4'b0001, 4'b0001, 1'b1);
            drain("drop");
            repeat (6) @(posedge c_clk);
            #1;
            check("drop_single_resp", 64'(resp_cnt[0] - c0), 64'd1);
            check("drop_data", 64'(last_data[0]), 64'd30);
        end

        // Port 3 alone wraps the pointer back to port 0.
        run1("wrap_p3", 3, CMD_ADD, 32'd7, 32'd8, RESP_OK, 32'd15);
        for (int p = 0; p < NP; p++) begin
            r_cmd[p] = CMD_ADD; r_op1[p] = 32'd1; r_op2[p] = DW'(p);
        end
        for (int round = 0; round < 2; round++) begin
            rsp_log.delete();
            issue_round(4'b1111, 4'b1111, 1'b0);
            drain($sformatf("rr%0d", round));
            check_order($sformatf("rr%0d", round), 0);
        end
        run1("ptr_p1", 1, CMD_SUB, 32'd9, 32'd4, RESP_OK, 32'd5);
        for (int p = 0; p < NP; p++) begin
            r_cmd[p] = CMD_ADD; r_op1[p] = 32'd1; r_op2[p] = DW'(p);
        end
        rsp_log.delete();
        issue_round(4'b1111, 4'b1111, 1'b0);
        drain("rr_from2");
        check_order("rr_from2", 2);

        // Abort port 1 while it waits behind port 0.
        begin
            int c1;
            r_cmd[0] = CMD_ADD; r_op1[0] = 32'd2; r_op2[0] = 32'd3;
            r_cmd[1] = CMD_SUB; r_op1[1] = 32'd9; r_op2[1] = 32'd4;
            issue_round(4'b0011, 4'b0001, 1'b0);
            @(posedge c_clk); #1;
            check("abort_p1_pending", 64'(bus.busy[1]), 64'd1);
            c1    = resp_cnt[1];
            reset = 1'b1;
            bus.req_cmd_in[8 +: 4] = CMD_ADD;
            @(posedge c_clk); #1;
            reset          = 1'b0;
            bus.req_cmd_in = '0;
            check("abort_busy", 64'(bus.busy), 64'd0);
            check("abort_resp", 64'(bus.out_resp), 64'd0);
            repeat (10) @(posedge c_clk);
            #1;
            check("abort_no_p1_resp", 64'(resp_cnt[1] - c1), 64'd0);
            check("abort_busy_after", 64'(bus.busy), 64'd0);
            for (int p = 0; p < NP; p++) exp_q[p].delete();
        end

        for (int round = 0; round < 40; round++) begin
            logic [NP-1:0] mask;
            mask = NP'($urandom_range(1, (1 << NP) - 1));
            for (int p = 0; p < NP; p++) begin
                case ($urandom_range(0, 9))
                    0, 1, 7: r_cmd[p] = CMD_ADD;
                    2, 3, 8: r_cmd[p] = CMD_SUB;
                    4:       r_cmd[p] = CMD_SHL;
                    5, 9:    r_cmd[p] = CMD_SHR;
                    default: r_cmd[p] = 4'($urandom_range(0, 15));
                endcase
                r_op1[p] = rand_val();
                r_op2[p] = rand_val();
            end
            issue_round(mask, mask, 1'b0);
            drain($sformatf("rand%0d", round));
        end

        begin
            int got0, got1;
            got0 = 0;
            got1 = 0;
            bus16.req_cmd_in  = {CMD_ADD, CMD_SHL};
            bus16.req_data_in = {16'hFFFF, 16'h0001};
            @(posedge c_clk); #1;
            bus16.req_cmd_in  = '0;
            bus16.req_data_in = {16'h0001, 16'h0013};
            for (int i = 0; i < 10; i++) begin
                @(negedge c_clk);
                if (bus16.out_resp[0:1] != 2'd0) begin
                    got0++;
                    check("w16_add_resp", 64'(bus16.out_resp[0:1]), 64'(RESP_OVF));
                    check("w16_add_data", 64'(bus16.out_data[0:15]), 64'd0);
                end
                if (bus16.out_resp[2:3] != 2'd0) begin
                    got1++;
                    check("w16_shl_resp", 64'(bus16.out_resp[2:3]), 64'(RESP_OK));
                    check("w16_shl_data", 64'(bus16.out_data[16:31]), 64'h8);
                end
            end
            check("w16_add_count", 64'(got0), 64'd1);
            check("w16_shl_count", 64'(got1), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
